// File: rtl/bev_dram_responder_if.sv
// AXI4-Lite channel bundle between the BEV bridge master and the DRAM responder.
interface bev_dram_responder_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64
);
    logic              AR_VALID;
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_READY;
    logic              R_VALID;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_READY;
    logic              AW_VALID;
    logic [ADDR_W-1:0] AW_ADDR;
    logic              AW_READY;
    logic              W_VALID;
    logic [DATA_W-1:0] W_DATA;
    logic              W_READY;
    logic              B_VALID;
    logic [1:0]        B_RESP;
    logic              B_READY;

    modport master (
        output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
        input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
    );

    modport slave (
        input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
        output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
    );
endinterface

// File: rtl/bev_dram_responder.sv
// AXI4-Lite DRAM model for the BEV bridge with fixed read/write latencies.
// Optional DRAM_ADDR_CHK_EN: out-of-window or misaligned accesses answer SLVERR.
//
// state   | meaning
// RD_IDLE | wait for AR_VALID
// RD_ACK  | AR_READY high, address handshake
// RD_WAIT | read latency countdown
// RD_RESP | R_VALID held until R_READY
// WR_IDLE | wait for AW_VALID
// WR_AACK | AW_READY high, address handshake
// WR_DATA | wait for W_VALID
// WR_DACK | W_READY high, data handshake
// WR_WAIT | write latency countdown
// WR_RESP | B_VALID held until B_READY
module bev_dram_responder #(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000,
    parameter int                DEPTH     = 256,
    parameter int                RD_LAT    = 4,
    parameter int                WR_LAT    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bev_dram_responder_if.slave  bus
);
    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_LAT - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_WAIT, RD_RESP} rd_state_e;
    typedef enum logic [2:0] {WR_IDLE, WR_AACK, WR_DATA, WR_DACK, WR_WAIT, WR_RESP} wr_state_e;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

`ifdef DRAM_ADDR_CHK_EN
    localparam logic [ADDR_W:0] ADDR_END = {1'b0, BASE_ADDR} + (ADDR_W+1)'(8 * DEPTH);

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < {1'b0, BASE_ADDR}) || ({1'b0, a} >= ADDR_END) || (a[2:0] != 3'b000);
    endfunction
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    rd_state_e         rd_state_q, rd_state_d;
    logic [3:0]        rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              rd_bad_q, rd_bad_d;
    logic              ar_ready_q, ar_ready_d;
    logic              r_valid_q, r_valid_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d;

    wr_state_e         wr_state_q, wr_state_d;
    logic [3:0]        wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              wr_bad_q, wr_bad_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              aw_ready_q, aw_ready_d;
    logic              w_ready_q, w_ready_d;
    logic              b_valid_q, b_valid_d;
    logic [1:0]        b_resp_q, b_resp_d;
    logic              wr_commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_idx_q   <= '0;
            rd_bad_q   <= 1'b0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= 2'b00;
            wr_state_q <= WR_IDLE;
            wr_cnt_q   <= '0;
            wr_idx_q   <= '0;
            wr_bad_q   <= 1'b0;
            wr_data_q  <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_idx_q   <= rd_idx_d;
            rd_bad_q   <= rd_bad_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_idx_q   <= wr_idx_d;
            wr_bad_q   <= wr_bad_d;
            wr_data_q  <= wr_data_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
        end
    end

    // A reset on the commit edge must drop the write, so rst_n gates the store.
    always_ff @(posedge clk) begin
        if (rst_n && wr_commit) begin
            mem[wr_idx_q] <= wr_data_q;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_idx_d   = rd_idx_q;
        rd_bad_d   = rd_bad_q;
        case (rd_state_q)
            RD_IDLE: if (bus.AR_VALID) begin
                rd_state_d = RD_ACK;
                rd_idx_d   = addr_idx(bus.AR_ADDR);
`ifdef DRAM_ADDR_CHK_EN
                rd_bad_d   = addr_bad(bus.AR_ADDR);
`else
                rd_bad_d   = 1'b0;
`endif
            end
            RD_ACK: begin
                rd_state_d = RD_WAIT;
                rd_cnt_d   = RD_CNT_INIT;
            end
            RD_WAIT: begin
                if (rd_cnt_q == 4'd0) rd_state_d = RD_RESP;
                else                  rd_cnt_d   = rd_cnt_q - 4'd1;
            end
            RD_RESP: if (bus.R_READY) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read data is sampled from memory only on entry to RD_RESP, then held.
    always_comb begin
        ar_ready_d = (rd_state_d == RD_ACK);
        r_valid_d  = (rd_state_d == RD_RESP);
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        if (rd_state_d != RD_RESP) begin
            r_data_d = '0;
            r_resp_d = 2'b00;
        end else if (rd_state_q != RD_RESP) begin
            r_data_d = rd_bad_q ? '0 : mem[rd_idx_q];
            r_resp_d = rd_bad_q ? 2'b10 : 2'b00;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_idx_d   = wr_idx_q;
        wr_bad_d   = wr_bad_q;
        wr_data_d  = wr_data_q;
        case (wr_state_q)
            WR_IDLE: if (bus.AW_VALID) begin
                wr_state_d = WR_AACK;
                wr_idx_d   = addr_idx(bus.AW_ADDR);
`ifdef DRAM_ADDR_CHK_EN
                wr_bad_d   = addr_bad(bus.AW_ADDR);
`else
                wr_bad_d   = 1'b0;
`endif
            end
            WR_AACK: wr_state_d = WR_DATA;
            WR_DATA: if (bus.W_VALID) begin
                wr_state_d = WR_DACK;
                wr_data_d  = bus.W_DATA;
            end
            WR_DACK: begin
                wr_state_d = WR_WAIT;
                wr_cnt_d   = WR_CNT_INIT;
            end
            WR_WAIT: begin
                if (wr_cnt_q == 4'd0) wr_state_d = WR_RESP;
                else                  wr_cnt_d   = wr_cnt_q - 4'd1;
            end
            WR_RESP: if (bus.B_READY) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        aw_ready_d = (wr_state_d == WR_AACK);
        w_ready_d  = (wr_state_d == WR_DACK);
        b_valid_d  = (wr_state_d == WR_RESP);
        wr_commit  = (wr_state_q == WR_WAIT) && (wr_state_d == WR_RESP) && !wr_bad_q;
        b_resp_d   = b_resp_q;
        if (wr_state_d != WR_RESP) begin
            b_resp_d = 2'b00;
        end else if (wr_state_q != WR_RESP) begin
            b_resp_d = wr_bad_q ? 2'b10 : 2'b00;
        end
    end

    assign bus.AR_READY = ar_ready_q;
    assign bus.R_VALID  = r_valid_q;
    assign bus.R_DATA   = r_data_q;
    assign bus.R_RESP   = r_resp_q;
    assign bus.AW_READY = aw_ready_q;
    assign bus.W_READY  = w_ready_q;
    assign bus.B_VALID  = b_valid_q;
    assign bus.B_RESP   = b_resp_q;
endmodule

// File: tb/tb_bev_dram_responder.sv
// Directed self-checking bench for bev_dram_responder (default latencies 4/4).
module tb_bev_dram_responder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bev_dram_responder_if #(.ADDR_W(17), .DATA_W(64)) bus ();

    bev_dram_responder #(
        .ADDR_W(17), .DATA_W(64), .BASE_ADDR(17'h10000),
        .DEPTH(256), .RD_LAT(4), .WR_LAT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [16:0] addr, input logic [63:0] data, input int hold,
                            input int early, output logic [1:0] resp, output int lat);
        int n;
        @(negedge clk);
        bus.W_DATA  = data;
        bus.B_READY = (hold == 0);
        if (early > 0) begin
            bus.W_VALID = 1'b1;
            repeat (early) begin
                @(negedge clk);
                check("w_ready_early", bus.W_READY, 1'b0);
            end
        end
        bus.AW_VALID = 1'b1;
        bus.AW_ADDR  = addr;
        n = 0;
        while (!bus.AW_READY && n < 20) begin @(negedge clk); n++; end
        check("aw_ready", bus.AW_READY, 1'b1);
        if (early > 0) check("w_ready_in_aw", bus.W_READY, 1'b0);
        @(posedge clk);
        #1;
        bus.AW_VALID = 1'b0;
        bus.W_VALID  = 1'b1;
        n = 0;
        while (!bus.W_READY && n < 20) begin @(negedge clk); n++; end
        check("w_ready", bus.W_READY, 1'b1);
        @(posedge clk);
        #1;
        bus.W_VALID = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.B_VALID && lat < 40);
        resp = bus.B_RESP;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("b_hold_valid", bus.B_VALID, 1'b1);
            check("b_hold_resp", bus.B_RESP, resp);
        end
        bus.B_READY = 1'b1;
        @(negedge clk);
        check("b_drop", bus.B_VALID, 1'b0);
        bus.B_READY = 1'b0;
    endtask

    task automatic do_read(input logic [16:0] addr, input int hold,
                           output logic [63:0] data, output logic [1:0] resp, output int lat);
        int n;
        @(negedge clk);
        bus.AR_VALID = 1'b1;
        bus.AR_ADDR  = addr;
        bus.R_READY  = (hold == 0);
        n = 0;
        while (!bus.AR_READY && n < 20) begin @(negedge clk); n++; end
        check("ar_ready", bus.AR_READY, 1'b1);
        @(posedge clk);
        #1;
        bus.AR_VALID = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.R_VALID && lat < 40);
        data = bus.R_DATA;
        resp = bus.R_RESP;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_hold_valid", bus.R_VALID, 1'b1);
            check("r_hold_data", bus.R_DATA, data);
        end
        bus.R_READY = 1'b1;
        @(negedge clk);
        check("r_drop_valid", bus.R_VALID, 1'b0);
        check("r_drop_data", bus.R_DATA, 64'h0);
        bus.R_READY = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ar_ready"}, bus.AR_READY, 1'b0);
        check({tag, "_r_valid"}, bus.R_VALID, 1'b0);
        check({tag, "_r_data"}, bus.R_DATA, 64'h0);
        check({tag, "_r_resp"}, bus.R_RESP, 2'b00);
        check({tag, "_aw_ready"}, bus.AW_READY, 1'b0);
        check({tag, "_w_ready"}, bus.W_READY, 1'b0);
        check({tag, "_b_valid"}, bus.B_VALID, 1'b0);
        check({tag, "_b_resp"}, bus.B_RESP, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  r;
        int          l;
        int          rl;
        int          bl;
        logic [63:0] rd;
        logic        seen_b;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.R_READY = 1'b0;
        bus.AW_VALID = 1'b0; bus.AW_ADDR = '0; bus.W_VALID = 1'b0;
        bus.W_DATA = '0; bus.B_READY = 1'b0;

        // reset and idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("rst");
        repeat (3) @(negedge clk);
        check_all_zero("idle");

        // basic write then read
        do_write(17'h10008, 64'hDEAD_BEEF_0123_4567, 0, 0, r, l);
        check("wr_b_lat", l, 5);
        check("wr_b_resp", r, 2'b00);
        do_read(17'h10008, 0, d, r, l);
        check("rd_lat", l, 5);
        check("rd_data", d, 64'hDEAD_BEEF_0123_4567);
        check("rd_resp", r, 2'b00);

        // backpressure on R and B
        do_read(17'h10008, 7, d, r, l);
        check("bp_rd_data", d, 64'hDEAD_BEEF_0123_4567);
        do_write(17'h10020, 64'h3C, 7, 0, r, l);
        check("bp_wr_lat", l, 5);
        do_read(17'h10020, 0, d, r, l);
        check("bp_wr_data", d, 64'h3C);

        // W_VALID before AW_VALID
        do_write(17'h10028, 64'h1, 0, 3, r, l);
        check("early_b_lat", l, 5);
        do_read(17'h10028, 0, d, r, l);
        check("early_data", d, 64'h1);

        // read and write to the same entry, AR and W handshakes in the same cycle
        do_write(17'h10010, 64'h5, 0, 0, r, l);
        @(negedge clk);
        bus.AW_VALID = 1'b1; bus.AW_ADDR = 17'h10010;
        bus.W_VALID = 1'b1; bus.W_DATA = 64'h9;
        bus.R_READY = 1'b1; bus.B_READY = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.AW_VALID = 1'b0;
        bus.AR_VALID = 1'b1; bus.AR_ADDR = 17'h10010;
        @(negedge clk);
        check("cc_ar_ready", bus.AR_READY, 1'b1);
        check("cc_w_ready", bus.W_READY, 1'b1);
        rl = 0; bl = 0; rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin bus.AR_VALID = 1'b0; bus.W_VALID = 1'b0; end
            if (bus.R_VALID && rl == 0) begin rl = k; rd = bus.R_DATA; end
            if (bus.B_VALID && bl == 0) bl = k;
        end
        bus.R_READY = 1'b0; bus.B_READY = 1'b0;
        check("cc_r_lat", rl, 5);
        check("cc_b_lat", bl, 5);
        check("cc_old_data", rd, 64'h5);
        do_read(17'h10010, 0, d, r, l);
        check("cc_new_data", d, 64'h9);

        // reset in the middle of a write drops it
        do_write(17'h10018, 64'h77, 0, 0, r, l);
        @(negedge clk);
        bus.AW_VALID = 1'b1; bus.AW_ADDR = 17'h10018;
        bus.W_VALID = 1'b1; bus.W_DATA = 64'hEE; bus.B_READY = 1'b1;
        l = 0;
        while (!bus.W_READY && l < 20) begin @(negedge clk); l++; end
        check("mr_w_ready", bus.W_READY, 1'b1);
        @(negedge clk);
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("mr");
        seen_b = 1'b0;
        repeat (8) begin @(negedge clk); seen_b = seen_b | bus.B_VALID; end
        bus.B_READY = 1'b0;
        check("mr_no_b", seen_b, 1'b0);
        do_read(17'h10018, 0, d, r, l);
        check("mr_mem_kept", d, 64'h77);

        // address window and alias behaviour
        do_write(17'h10000, 64'hA5A5_0000_0000_0001, 0, 0, r, l);
        do_write(17'h107F8, 64'hFF00_0000_0000_00FF, 0, 0, r, l);
        do_read(17'h10804, 0, d, r, l);
        check("oob_rd_lat", l, 5);
`ifdef DRAM_ADDR_CHK_EN
        check("oob_rd_resp", r, 2'b10);
        check("oob_rd_data", d, 64'h0);
        do_write(17'h0FFF8, 64'hBAD, 0, 0, r, l);
        check("oob_wr_resp", r, 2'b10);
        check("oob_wr_lat", l, 5);
        do_read(17'h10000, 0, d, r, l);
        check("oob_idx0", d, 64'hA5A5_0000_0000_0001);
        check("oob_idx0_resp", r, 2'b00);
        do_read(17'h107F8, 0, d, r, l);
        check("oob_idx255", d, 64'hFF00_0000_0000_00FF);
`else
        check("alias_rd_resp", r, 2'b00);
        check("alias_rd_data", d, 64'hA5A5_0000_0000_0001);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
